// File: rtl/alu_pkg.sv
// Shared types and helpers for the 8-bit ALU issue path.
package alu_pkg;

    localparam int unsigned OPER_W = 3;
    localparam int unsigned DATA_W = 8;

    // Encodings 000, 101 and 111 are intentionally unnamed: they are the illegal opcodes.
    typedef enum logic [OPER_W-1:0] {
        AND = 3'b001,
        SUB = 3'b010,
        XOR = 3'b011,
        ADD = 3'b100,
        OR  = 3'b110
    } aluInstr;

    typedef struct packed {
        aluInstr           oper;
        logic [DATA_W-1:0] inA;
        logic [DATA_W-1:0] inB;
    } command_t;

    function automatic logic is_legal_op(aluInstr op);
        case (op)
            ADD, SUB, AND, OR, XOR: is_legal_op = 1'b1;
            default:                is_legal_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/aluWithEnums.sv
// Combinational 8-bit ALU; carry output exists only when ALU_FLAGS_EN is defined.
module aluWithEnums
    import alu_pkg::*;
(
    input  aluInstr           oper_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] result_o
`ifdef ALU_FLAGS_EN
    ,
    output logic              carry_o
`endif
);

    always_comb begin
        result_o = '0;
        case (oper_i)
            ADD:     result_o = a_i + b_i;
            SUB:     result_o = a_i - b_i;
            AND:     result_o = a_i & b_i;
            OR:      result_o = a_i | b_i;
            XOR:     result_o = a_i ^ b_i;
            default: result_o = '0;
        endcase
    end

`ifdef ALU_FLAGS_EN
    logic [DATA_W:0] sum;
    assign sum = {1'b0, a_i} + {1'b0, b_i};

    // SUB reports borrow, not the inverted adder carry.
    always_comb begin
        carry_o = 1'b0;
        case (oper_i)
            ADD:     carry_o = sum[DATA_W];
            SUB:     carry_o = (a_i < b_i);
            default: carry_o = 1'b0;
        endcase
    end
`endif

endmodule

// File: rtl/alu_cmd_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with registered storage and an occupancy count.
module alu_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 19
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   level_q, level_d;
    logic             do_push, do_pop;

    assign full_o  = (level_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign level_o = level_q;

    always_comb begin
        level_d = level_q;
        if (do_push && !do_pop) begin
            level_d = level_q + 1'b1;
        end else if (!do_push && do_pop) begin
            level_d = level_q - 1'b1;
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/alu_cmd_issue.sv
// ALU issue stage: command FIFO, illegal-opcode filter, ALU and registered output stage.
// Define ALU_FLAGS_EN to add registered out_zero_o / out_carry_o flags.
module alu_cmd_issue
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [$bits(command_t)-1:0] in_cmd_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [DATA_W-1:0]          out_result_o,
    output logic [OPER_W-1:0]          out_oper_o,
    output logic                       err_illegal_o,
    output logic [CNT_W-1:0]           illegal_cnt_o,
    output logic [$clog2(DEPTH):0]     level_o
`ifdef ALU_FLAGS_EN
    ,
    output logic                       out_zero_o,
    output logic                       out_carry_o
`endif
);

    typedef enum logic {StEmpty, StFull} stage_e;

    command_t                    in_cmd, head;
    logic [$bits(command_t)-1:0] head_raw;
    logic                        fifo_full, fifo_empty;
    logic                        accept, legal, push, load;
    logic [DATA_W-1:0]           alu_result;

    stage_e                      stage_q;
    logic [DATA_W-1:0]           result_q;
    logic [OPER_W-1:0]           oper_q;
    logic                        err_q;
    logic [CNT_W-1:0]            cnt_q;

    assign in_cmd = command_t'(in_cmd_i);
    assign head   = command_t'(head_raw);
    assign legal  = is_legal_op(in_cmd.oper);
    assign accept = in_valid_i & ~fifo_full;
    assign push   = accept & legal;
    assign load   = ~fifo_empty & ((stage_q == StEmpty) | out_ready_i);

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(command_t))
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (push),
        .wdata_i (in_cmd),
        .pop_i   (load),
        .rdata_o (head_raw),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level_o)
    );

`ifdef ALU_FLAGS_EN
    logic alu_carry, zero_q, carry_q;
`endif

    aluWithEnums u_alu (
        .oper_i   (head.oper),
        .a_i      (head.inA),
        .b_i      (head.inB),
        .result_o (alu_result)
`ifdef ALU_FLAGS_EN
        ,
        .carry_o  (alu_carry)
`endif
    );

    // A load while FULL replaces the consumed entry, giving one result per cycle.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            stage_q  <= StEmpty;
            result_q <= '0;
            oper_q   <= '0;
`ifdef ALU_FLAGS_EN
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
`endif
        end else if (load) begin
            stage_q  <= StFull;
            result_q <= alu_result;
            oper_q   <= head.oper;
`ifdef ALU_FLAGS_EN
            zero_q   <= (alu_result == '0);
            carry_q  <= alu_carry;
`endif
        end else if (stage_q == StFull && out_ready_i) begin
            stage_q  <= StEmpty;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            err_q <= accept & ~legal;
            if (accept && !legal && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign in_ready_o    = ~fifo_full;
    assign out_valid_o   = (stage_q == StFull);
    assign out_result_o  = result_q;
    assign out_oper_o    = oper_q;
    assign err_illegal_o = err_q;
    assign illegal_cnt_o = cnt_q;
`ifdef ALU_FLAGS_EN
    assign out_zero_o    = zero_q;
    assign out_carry_o   = carry_q;
`endif

endmodule
